dtw_result_collector: RTL and testbench

DTW_RESULT_COLLECTOR -- requirements
Module: dtw_result_collector

---
 rtl/dtw_result_collector.sv | 118 +++++++++++
 tb/tb_dtw_result_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_result_collector.sv
// Collects 3-word DTW result records (qid, position, minval) from a FWFT FIFO
// and presents them on a valid/ready port, with hit flagging and best-hit tracking.
module dtw_result_collector #(
    parameter int dtw_dwidth = 16,
    parameter int axi_dwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [dtw_dwidth-1:0] threshold,
    input  logic                  clear_best,
    input  logic                  fifo_empty,
    input  logic [axi_dwidth-1:0] fifo_data,
    output logic                  fifo_rden,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [axi_dwidth-1:0] res_qid,
    output logic [axi_dwidth-1:0] res_position,
    output logic [dtw_dwidth-1:0] res_minval,
    output logic                  res_hit,
    output logic [axi_dwidth-1:0] res_count,
    output logic                  best_valid,
    output logic [axi_dwidth-1:0] best_qid,
    output logic [dtw_dwidth-1:0] best_minval,
    output logic                  fmt_err,
    output logic [1:0]            fsm_state
);

    // Result handshake: a record transfers on any rising edge where
    // res_valid=1 and res_ready=1; while res_valid=1 all res_* fields hold.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] word_idx;
    logic       consume;
    logic       handshake;
    logic       take_best;

    assign consume   = (state == COLLECT) && !fifo_empty;
    assign handshake = (state == PRESENT) && res_valid && res_ready;
    // Clearing on the handshake edge still installs the departing record.
    assign take_best = handshake && (!best_valid || clear_best || (res_minval < best_minval));

    assign fifo_rden = consume;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word_idx     <= 2'd0;
            res_valid    <= 1'b0;
            res_qid      <= '0;
            res_position <= '0;
            res_minval   <= '0;
            res_hit      <= 1'b0;
            res_count    <= '0;
            best_valid   <= 1'b0;
            best_qid     <= '0;
            best_minval  <= '0;
            fmt_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= COLLECT;
                        word_idx <= 2'd0;
                    end
                end
                COLLECT: begin
                    if (consume) begin
                        case (word_idx)
                            2'd0: begin
                                res_qid  <= fifo_data;
                                word_idx <= 2'd1;
                            end
                            2'd1: begin
                                res_position <= fifo_data;
                                word_idx     <= 2'd2;
                            end
                            2'd2: begin
                                res_minval <= fifo_data[dtw_dwidth-1:0];
                                res_hit    <= (fifo_data[dtw_dwidth-1:0] < threshold);
                                if (fifo_data[axi_dwidth-1:dtw_dwidth] != '0)
                                    fmt_err <= 1'b1;
                                word_idx  <= 2'd0;
                                res_valid <= 1'b1;
                                state     <= PRESENT;
                            end
                            default: word_idx <= 2'd0;
                        endcase
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        res_valid <= 1'b0;
                        res_count <= res_count + {{(axi_dwidth-1){1'b0}}, 1'b1};
                        word_idx  <= 2'd0;
                        state     <= enable ? COLLECT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (take_best) begin
                best_valid  <= 1'b1;
                best_qid    <= res_qid;
                best_minval <= res_minval;
            end else if (clear_best) begin
                best_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dtw_result_collector.sv
// Directed bench for dtw_result_collector: a queue-backed FWFT FIFO model feeds
// records, and each scenario task checks outputs against hand-computed values.
module tb_dtw_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] threshold = 16'h0100;
    logic        clear_best = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rden;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_qid, res_position, res_count, best_qid;
    logic [15:0] res_minval, best_minval;
    logic        res_hit, best_valid, fmt_err;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int hs_seen = 0;
    logic pop_pending = 1'b0;
    logic [31:0] fifo_q[$];

    dtw_result_collector #(.dtw_dwidth(16), .axi_dwidth(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .threshold(threshold),
        .clear_best(clear_best), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rden(fifo_rden), .res_valid(res_valid), .res_ready(res_ready),
        .res_qid(res_qid), .res_position(res_position), .res_minval(res_minval),
        .res_hit(res_hit), .res_count(res_count), .best_valid(best_valid),
        .best_qid(best_qid), .best_minval(best_minval), .fmt_err(fmt_err),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / FIFO model ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic fifo_drive();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    initial fifo_drive();

    always @(negedge clk) begin
        pop_pending = fifo_rden && !fifo_empty;
        if (res_valid && res_ready) hs_seen++;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            void'(fifo_q.pop_front());
            rd_pulses++;
            pop_pending = 1'b0;
        end
        fifo_drive();
    end

    // ---------------- driver tasks ----------------
    task automatic send_record(input logic [31:0] qid, input logic [31:0] pos,
                               input logic [31:0] w2);
        @(posedge clk); #1;
        fifo_q.push_back(qid);
        fifo_q.push_back(pos);
        fifo_q.push_back(w2);
        fifo_drive();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout got %b expected 1", name, res_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", res_valid); end
        checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b expected 0", fifo_rden); end
        checks++; if (res_count !== 32'h0) begin errors++; $display("FAIL reset_count got %h expected 0", res_count); end
        checks++; if (res_qid !== 32'h0 || res_minval !== 16'h0) begin errors++; $display("FAIL reset_fields got %h/%h expected 0/0", res_qid, res_minval); end
        checks++; if (best_valid !== 1'b0 || fmt_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b/%b expected 0/0", best_valid, fmt_err); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", fsm_state); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        threshold = 16'h0100;
        res_ready = 1'b1;
        enable    = 1'b1;
        rd_pulses = 0;
        send_record(32'h7, 32'h1F4, 32'h00C8);
        wait_valid("single");
        checks++; if (res_qid !== 32'h7) begin errors++; $display("FAIL single_qid got %h expected 7", res_qid); end
        checks++; if (res_position !== 32'd500) begin errors++; $display("FAIL single_pos got %0d expected 500", res_position); end
        checks++; if (res_minval !== 16'd200) begin errors++; $display("FAIL single_minval got %0d expected 200", res_minval); end
        checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL single_hit got %b expected 1", res_hit); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b expected 0", res_valid); end
        checks++; if (res_count !== 32'd1) begin errors++; $display("FAIL single_count got %0d expected 1", res_count); end
        checks++; if (hs_seen !== 1) begin errors++; $display("FAIL single_hs got %0d expected 1", hs_seen); end
        checks++; if (rd_pulses !== 3) begin errors++; $display("FAIL single_rden got %0d expected 3", rd_pulses); end
        checks++; if (best_valid !== 1'b1 || best_qid !== 32'h7 || best_minval !== 16'd200) begin
            errors++; $display("FAIL single_best got %b/%h/%0d expected 1/7/200", best_valid, best_qid, best_minval); end
    endtask

    task automatic test_back_pressure();
        @(posedge clk); #1;
        res_ready = 1'b0;
        fifo_q.push_back(32'h11);
        fifo_q.push_back(32'h22);
        fifo_drive();
        repeat (7) @(posedge clk);
        #1;
        checks++; if (rd_pulses !== 5) begin errors++; $display("FAIL stall_reads got %0d expected 5", rd_pulses); end
        checks++; if (fsm_state !== 2'd1 || fifo_rden !== 1'b0) begin errors++; $display("FAIL stall_state got %0d/%b expected 1/0", fsm_state, fifo_rden); end
        fifo_q.push_back(32'h0180);
        fifo_drive();
        wait_valid("stall");
        checks++; if (res_qid !== 32'h11 || res_position !== 32'h22 || res_minval !== 16'h0180) begin
            errors++; $display("FAIL stall_fields got %h/%h/%h expected 11/22/180", res_qid, res_position, res_minval); end
        checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL stall_hit got %b expected 0", res_hit); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL hold_rden cycle %0d got %b expected 0", i, fifo_rden); end
            checks++; if (res_valid !== 1'b1 || res_qid !== 32'h11 || res_minval !== 16'h0180) begin
                errors++; $display("FAIL hold_fields cycle %0d got %b/%h/%h expected 1/11/180", i, res_valid, res_qid, res_minval); end
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || hs_seen !== 2) begin errors++; $display("FAIL stall_once got %b/%0d expected 0/2", res_valid, hs_seen); end
        checks++; if (res_count !== 32'd2 || rd_pulses !== 6) begin errors++; $display("FAIL stall_count got %0d/%0d expected 2/6", res_count, rd_pulses); end
        checks++; if (best_qid !== 32'h7 || best_minval !== 16'd200) begin errors++; $display("FAIL stall_best got %h/%0d expected 7/200", best_qid, best_minval); end
    endtask

    task automatic test_best();
        clear_best = 1'b1;
        @(posedge clk); #1;
        clear_best = 1'b0;
        @(negedge clk);
        checks++; if (best_valid !== 1'b0) begin errors++; $display("FAIL best_clear got %b expected 0", best_valid); end
        send_record(32'h21, 32'h1, 32'd300);
        wait_valid("best1");
        @(negedge clk);
        checks++; if (best_valid !== 1'b1 || best_qid !== 32'h21 || best_minval !== 16'd300) begin
            errors++; $display("FAIL best_r1 got %b/%h/%0d expected 1/21/300", best_valid, best_qid, best_minval); end
        send_record(32'h22, 32'h2, 32'd150);
        wait_valid("best2");
        checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL best_r2_hit got %b expected 1", res_hit); end
        @(negedge clk);
        checks++; if (best_qid !== 32'h22 || best_minval !== 16'd150) begin errors++; $display("FAIL best_r2 got %h/%0d expected 22/150", best_qid, best_minval); end
        send_record(32'h23, 32'h3, 32'd150);
        wait_valid("best3");
        @(negedge clk);
        checks++; if (best_qid !== 32'h22 || best_minval !== 16'd150) begin errors++; $display("FAIL best_tie got %h/%0d expected 22/150", best_qid, best_minval); end
        res_ready = 1'b0;
        send_record(32'h24, 32'h4, 32'd400);
        wait_valid("best4");
        res_ready  = 1'b1;
        clear_best = 1'b1;
        @(posedge clk); #1;
        clear_best = 1'b0;
        @(negedge clk);
        checks++; if (best_valid !== 1'b1 || best_qid !== 32'h24 || best_minval !== 16'd400) begin
            errors++; $display("FAIL best_clear_hs got %b/%h/%0d expected 1/24/400", best_valid, best_qid, best_minval); end
    endtask

    task automatic test_fmt_err();
        threshold = 16'h0010;
        send_record(32'h51, 32'h52, 32'h0001_0010);
        wait_valid("fmt1");
        checks++; if (res_minval !== 16'h0010) begin errors++; $display("FAIL fmt_minval got %h expected 0010", res_minval); end
        checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL fmt_hit_equal got %b expected 0", res_hit); end
        checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_set got %b expected 1", fmt_err); end
        @(negedge clk);
        send_record(32'h53, 32'h54, 32'h0000_000F);
        wait_valid("fmt2");
        checks++; if (res_hit !== 1'b1 || res_minval !== 16'h000F) begin errors++; $display("FAIL fmt_below got %b/%h expected 1/000F", res_hit, res_minval); end
        checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_sticky got %b expected 1", fmt_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int hs_before;
        @(posedge clk); #1;
        fifo_q.push_back(32'h31);
        fifo_q.push_back(32'h32);
        fifo_drive();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (res_count !== 32'h0 || fmt_err !== 1'b0 || best_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_clear got %0d/%b/%b expected 0/0/0", res_count, fmt_err, best_valid); end
        checks++; if (res_valid !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state got %b/%0d expected 0/0", res_valid, fsm_state); end
        hs_before = hs_seen;
        threshold = 16'h0100;
        send_record(32'h41, 32'h42, 32'h0050);
        wait_valid("rst_mid");
        checks++; if (res_qid !== 32'h41 || res_position !== 32'h42 || res_minval !== 16'h0050 || res_hit !== 1'b1) begin
            errors++; $display("FAIL rst_mid_fields got %h/%h/%h/%b expected 41/42/0050/1", res_qid, res_position, res_minval, res_hit); end
        @(negedge clk);
        checks++; if (res_count !== 32'd1 || hs_seen !== hs_before + 1) begin
            errors++; $display("FAIL rst_mid_count got %0d/%0d expected 1/%0d", res_count, hs_seen, hs_before + 1); end
    endtask

    task automatic test_wrap_enable();
        int rd_before;
        @(posedge clk); #1;
        force dut.res_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.res_count;
        send_record(32'h61, 32'h62, 32'h0070);
        wait_valid("wrap");
        enable = 1'b0;
        @(negedge clk);
        checks++; if (res_count !== 32'h0) begin errors++; $display("FAIL wrap_count got %h expected 0", res_count); end
        checks++; if (fsm_state !== 2'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle got %0d/%b expected 0/0", fsm_state, res_valid); end
        rd_before = rd_pulses;
        @(posedge clk); #1;
        fifo_q.push_back(32'hAA);
        fifo_drive();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL idle_rden cycle %0d got %b expected 0", i, fifo_rden); end
        end
        checks++; if (rd_pulses !== rd_before || fifo_q.size() !== 1) begin
            errors++; $display("FAIL idle_no_read got %0d/%0d expected %0d/1", rd_pulses, fifo_q.size(), rd_before); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_best();
        test_fmt_err();
        test_reset_mid();
        test_wrap_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
